mdio_arbiter: RTL and testbench

Round-robin scheduler that shares the single MDIO frame generator between NREQ management requesters.
- Grants one requester at a time.
- Packs its Clause-22 fields into the 32-bit frame word t_data.
- Pulses mdio_start once, waits for the generator's completion, then returns read data (or a timeout error) to the granted requester.
- Sits between the management clients and the MDIO generator; it is the only driver of mdio_start/t_data.

---
 rtl/mdio_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mdio_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_arbiter.sv
// mdio_arbiter: round-robin arbiter feeding Clause-22 frames to one MDIO generator
module mdio_arbiter #(
    parameter int NREQ        = 2,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_write,
    input  logic [5*NREQ-1:0] req_phyad,
    input  logic [5*NREQ-1:0] req_regad,
    input  logic [16*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [15:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mdio_start,
    output logic [31:0]       t_data,
    input  logic              mdio_done,
    input  logic [15:0]       mdio_rdata,
    output logic              busy
);
    localparam int LW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT_CYC);

    typedef enum logic [2:0] {IDLE, GRANT, START, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   grant_q, grant_d;
    logic [LW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic [31:0]     t_data_q, t_data_d;
    logic            mdio_start_q, mdio_start_d;
    logic [NREQ-1:0] req_ready_q, req_ready_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [15:0]     rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;
    logic            busy_q, busy_d;

    logic [4:0]      phy_a [NREQ];
    logic [4:0]      reg_a [NREQ];
    logic [15:0]     wd_a  [NREQ];
    logic [LW-1:0]   pick, idx;
    logic            found;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign phy_a[i] = req_phyad[5*i +: 5];
        assign reg_a[i] = req_regad[5*i +: 5];
        assign wd_a[i]  = req_wdata[16*i +: 16];
    end

    // Search for the first pending requester after the last one served, wrapping
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = LW'((int'(last_q) + i) % NREQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        t_data_d     = t_data_q;
        mdio_start_d = 1'b0;
        req_ready_d  = '0;
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d            = GRANT;
                    grant_d            = pick;
                    wr_d               = req_write[pick];
                    req_ready_d[pick]  = 1'b1;
                    t_data_d = {2'b01, req_write[pick] ? 2'b01 : 2'b10, phy_a[pick], reg_a[pick],
                                req_write[pick] ? 2'b10 : 2'b00, req_write[pick] ? wd_a[pick] : 16'h0000};
                end
            end
            GRANT: begin
                state_d      = START;
                mdio_start_d = 1'b1;
            end
            START: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (mdio_done) begin
                    state_d              = RESP;
                    rsp_valid_d[grant_q] = 1'b1;
                    rsp_rdata_d          = wr_q ? 16'h0000 : mdio_rdata;
                    rsp_err_d            = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    state_d              = RESP;
                    rsp_valid_d[grant_q] = 1'b1;
                    rsp_rdata_d          = 16'hFFFF;
                    rsp_err_d            = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                last_d  = grant_q;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_q       <= LW'(NREQ - 1);
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            t_data_q     <= '0;
            mdio_start_q <= 1'b0;
            req_ready_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            t_data_q     <= t_data_d;
            mdio_start_q <= mdio_start_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_err    = rsp_err_q;
    assign mdio_start = mdio_start_q;
    assign t_data     = t_data_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_mdio_arbiter.sv
// tb_mdio_arbiter: randomized and directed bench with a transaction-age reference model
module tb_mdio_arbiter;
    localparam int N  = 2;
    localparam int TO = 256;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_write;
    logic [5*N-1:0]  req_phyad, req_regad;
    logic [16*N-1:0] req_wdata;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [15:0]     rsp_rdata;
    logic            rsp_err, mdio_start;
    logic [31:0]     t_data;
    logic            mdio_done;
    logic [15:0]     mdio_rdata;
    logic            busy;

    int checks = 0, failures = 0, cyc = 0;

    mdio_arbiter #(.NREQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_phyad(req_phyad), .req_regad(req_regad), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mdio_start(mdio_start), .t_data(t_data),
        .mdio_done(mdio_done), .mdio_rdata(mdio_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: age = cycles since the grant (-1 when nothing in flight)
    int          m_age = -1, m_g = 0, m_last = N - 1;
    bit          m_resp = 0, m_wr = 0, m_err = 0;
    logic [31:0] m_t = '0;
    logic [15:0] m_rd = '0;
    logic [N-1:0] e_ready, e_rv;

    // Event log for the directed literal checks
    int          ready_cyc = 0, start_cyc = 0, rsp_cyc = 0, rsp_cnt = 0;
    logic [31:0] start_t = '0;

    // Advance the model on each edge, then compare every output a moment later
    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            m_age = -1; m_resp = 0; m_last = N - 1; m_g = 0;
            m_t = '0; m_rd = '0; m_err = 0; m_wr = 0;
        end else if (m_resp) begin
            m_resp = 0;
            m_last = m_g;
        end else if (m_age < 0) begin
            for (int k = 1; k <= N; k++)
                if (m_age < 0 && req_valid[(m_last + k) % N]) begin
                    m_g   = (m_last + k) % N;
                    m_age = 0;
                end
            if (m_age == 0) begin
                m_wr = req_write[m_g];
                m_t  = {2'b01, m_wr ? 2'b01 : 2'b10, req_phyad[5*m_g +: 5], req_regad[5*m_g +: 5],
                        m_wr ? 2'b10 : 2'b00, m_wr ? req_wdata[16*m_g +: 16] : 16'h0000};
            end
        end else if (m_age < 2) begin
            m_age++;
        end else if (mdio_done) begin
            m_age = -1; m_resp = 1; m_rd = m_wr ? 16'h0000 : mdio_rdata; m_err = 0;
        end else if (m_age - 1 == TO) begin
            m_age = -1; m_resp = 1; m_rd = 16'hFFFF; m_err = 1;
        end else begin
            m_age++;
        end
        e_ready = '0;
        e_rv    = '0;
        if (m_age == 0) e_ready[m_g] = 1'b1;
        if (m_resp) e_rv[m_g] = 1'b1;
        #1;
        chk("req_ready", req_ready, e_ready);
        chk("rsp_valid", rsp_valid, e_rv);
        chk("mdio_start", mdio_start, m_age == 1);
        chk("busy", busy, m_age >= 0 || m_resp);
        chk("t_data", t_data, m_t);
        chk("rsp_rdata", rsp_rdata, m_rd);
        chk("rsp_err", rsp_err, m_err);
        if (req_ready != 0) ready_cyc = cyc;
        if (mdio_start) begin start_cyc = cyc; start_t = t_data; end
        if (rsp_valid != 0) begin rsp_cyc = cyc; rsp_cnt++; end
    end

    // MDIO generator stand-in: completes after gen_delay WAIT cycles (0 = never)
    int          gen_delay = 4, gen_left = 0, inj_cnt = 0, inj_seen = 0;
    bit          gen_rand = 0;
    logic [15:0] gen_fix = 16'h1234, gen_data = '0;
    always @(negedge clk) begin
        mdio_done = 1'b0;
        if (!reset) gen_left = 0;
        if (inj_cnt != inj_seen) begin
            inj_seen   = inj_cnt;
            mdio_done  = 1'b1;
            mdio_rdata = 16'($urandom);
        end else if (gen_left > 0) begin
            gen_left--;
            if (gen_left == 0) begin
                mdio_done  = 1'b1;
                mdio_rdata = gen_data;
            end
        end
        if (mdio_start) begin
            gen_left = gen_rand ? (($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 12)) : gen_delay;
            gen_data = gen_rand ? 16'($urandom) : gen_fix;
        end
    end

    task automatic set_req(input int i, input bit wr, input logic [4:0] phy, input logic [4:0] rg,
                           input logic [15:0] wd);
        req_write[i]         = wr;
        req_phyad[5*i +: 5]  = phy;
        req_regad[5*i +: 5]  = rg;
        req_wdata[16*i +: 16] = wd;
        req_valid[i]         = 1'b1;
    endtask

    task automatic rand_req(input int i);
        set_req(i, 1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
    endtask

    task automatic wait_ready(input int i);
        int n = 0;
        while (!req_ready[i] && n < 2000) begin @(negedge clk); n++; end
        chk("ready_seen", req_ready[i], 1'b1);
    endtask

    task automatic do_txn(input int i, input bit wr, input logic [4:0] phy, input logic [4:0] rg,
                          input logic [15:0] wd, output int t_set);
        int n = 0;
        @(negedge clk);
        set_req(i, wr, phy, rg, wd);
        t_set = cyc;
        wait_ready(i);
        req_valid[i] = 1'b0;
        while (!rsp_valid[i] && n < 2000) begin @(negedge clk); n++; end
        chk("rsp_seen", rsp_valid[i], 1'b1);
    endtask

    task automatic serve_all();
        int n = 0;
        while ((req_valid != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < N; i++) if (req_ready[i]) req_valid[i] = 1'b0;
        end
        chk("drain_busy", busy, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
    endtask

    initial begin
        int ts, rc0, n;
        int ord[4], rcy[4];
        reset = 1'b0; req_valid = '0; req_write = '0; req_phyad = '0; req_regad = '0; req_wdata = '0;
        mdio_done = 1'b0; mdio_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_t_data", t_data, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", req_ready, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        gen_delay = 64;
        do_txn(0, 1'b1, 5'h15, 5'h18, 16'h7654, ts);
        chk("t1_ready_lat", ready_cyc - ts, 1);
        chk("t1_start_lat", start_cyc - ready_cyc, 1);
        chk("t1_t_data", start_t, 32'h5AE27654);
        chk("t1_rsp_lat", rsp_cyc - start_cyc, 65);
        chk("t1_rdata", rsp_rdata, 16'h0000);
        chk("t1_err", rsp_err, 1'b0);

        gen_delay = 5; gen_fix = 16'hBEEF;
        do_txn(1, 1'b0, 5'h15, 5'h18, 16'hAAAA, ts);
        chk("t2_t_data", start_t, 32'h6AE00000);
        chk("t2_rdata", rsp_rdata, 16'hBEEF);
        chk("t2_err", rsp_err, 1'b0);

        gen_delay = 3;
        pulse_reset();
        rand_req(0); rand_req(1);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (req_ready == 0 && n < 2000);
            ord[k] = req_ready[1] ? 1 : 0;
            rcy[k] = cyc;
            rand_req(ord[k]);
        end
        req_valid = '0;
        serve_all();
        chk("rr_0", ord[0], 0); chk("rr_1", ord[1], 1); chk("rr_2", ord[2], 0); chk("rr_3", ord[3], 1);
        for (int k = 1; k < 4; k++) chk("rr_gap", rcy[k] - rcy[k-1], 7);

        gen_delay = 0;
        do_txn(0, 1'b0, 5'h01, 5'h02, 16'h0, ts);
        chk("to_lat", rsp_cyc - start_cyc, TO + 1);
        chk("to_rdata", rsp_rdata, 16'hFFFF);
        chk("to_err", rsp_err, 1'b1);
        gen_delay = 2; gen_fix = 16'h5A5A;
        do_txn(1, 1'b0, 5'h03, 5'h04, 16'h0, ts);
        chk("after_to_rdata", rsp_rdata, 16'h5A5A);
        chk("after_to_err", rsp_err, 1'b0);

        gen_delay = TO; gen_fix = 16'hC0DE;
        do_txn(0, 1'b0, 5'h07, 5'h08, 16'h0, ts);
        chk("edge_lat", rsp_cyc - start_cyc, TO + 1);
        chk("edge_rdata", rsp_rdata, 16'hC0DE);
        chk("edge_err", rsp_err, 1'b0);

        rc0 = rsp_cnt;
        @(negedge clk) inj_cnt++;
        repeat (5) @(negedge clk);
        chk("idle_done_rsp", rsp_cnt - rc0, 0);
        chk("idle_done_busy", busy, 1'b0);

        gen_delay = 100;
        @(negedge clk);
        set_req(0, 1'b1, 5'h0A, 5'h0B, 16'h1111);
        wait_ready(0);
        req_valid[0] = 1'b0;
        n = 0;
        while (!mdio_start && n < 100) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        rc0 = rsp_cnt;
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("ar_t_data", t_data, 32'h0);
        chk("ar_start", mdio_start, 1'b0);
        chk("ar_ready", req_ready, 0);
        chk("ar_rsp_valid", rsp_valid, 0);
        chk("ar_rdata", rsp_rdata, 16'h0);
        chk("ar_err", rsp_err, 1'b0);
        chk("ar_busy", busy, 1'b0);
        gen_delay = 4;
        repeat (2) @(negedge clk);
        chk("ar_no_rsp", rsp_cnt - rc0, 0);
        set_req(1, 1'b0, 5'h11, 5'h12, 16'h0);
        reset = 1'b1;
        wait_ready(1);
        chk("ar_grant_lone1", req_ready, 2'b10);
        req_valid[1] = 1'b0;
        serve_all();
        @(negedge clk) reset = 1'b0;
        rand_req(0); rand_req(1);
        @(negedge clk) reset = 1'b1;
        n = 0;
        while (req_ready == 0 && n < 100) begin @(negedge clk); n++; end
        chk("ar_grant_both", req_ready, 2'b01);
        serve_all();

        gen_rand = 1'b1;
        repeat (3000) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    if ($urandom_range(0, 1) == 1) req_valid[i] = 1'b0; else rand_req(i);
                end else if (req_valid[i]) begin
                    if ($urandom_range(0, 31) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    rand_req(i);
                end
            end
            if (!busy && $urandom_range(0, 40) == 0) inj_cnt++;
        end
        req_valid = '0;
        serve_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end
endmodule
